// File: rtl/led_seq_pkg.sv
// Shared mode/state encodings for the LED sequencer and its prescaler.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT_L = 2'b00,
        MODE_SHIFT_R = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_COUNT   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    // Every pattern except COUNT keeps a single lit LED.
    function automatic logic isOneHot(input mode_t m);
        return (m != MODE_COUNT);
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Runtime-rate prescaler: counts 0..R-1 with R = max(rate,1) and flags the terminal cycle.
module led_seq_prescaler
    import led_seq_pkg::*;
#(
    parameter int CNT_WIDTH = 25
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [CNT_WIDTH-1:0] i_rate,
    output logic                 o_terminal
);

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_rateEff;
    logic [CNT_WIDTH-1:0] w_limit;

    assign w_rateEff = (i_rate == '0) ? CNT_WIDTH'(1) : i_rate;
    assign w_limit   = w_rateEff - CNT_WIDTH'(1);

    // Using >= lets a lowered rate terminate at once rather than wrap the counter.
    assign o_terminal = i_enable && !i_clear && (r_count >= w_limit);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (o_terminal) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Parametrised LED pattern generator (shift left/right, bounce, count) with hold and single-step.
// Define LED_SEQ_GRAY_EN to drive COUNT mode as Gray code from an internal binary counter.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 25
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic [1:0]           i_mode,
    input  logic [CNT_WIDTH-1:0] i_rate,
    input  logic                 i_step,
    output logic [WIDTH-1:0]     o_leds,
    output logic                 o_tick,
    output logic                 o_wrap
);

    localparam logic [WIDTH-1:0] LP_LSB = WIDTH'(1);
    localparam logic [WIDTH-1:0] LP_MSB = LP_LSB << (WIDTH - 1);

    function automatic logic [WIDTH-1:0] initPattern(input mode_t m);
        logic [WIDTH-1:0] pattern;
        case (m)
            MODE_SHIFT_R: pattern = LP_MSB;
            MODE_COUNT:   pattern = '0;
            default:      pattern = LP_LSB;
        endcase
        return pattern;
    endfunction

    state_t           r_state;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_leds;
    logic             r_tick;
    logic             r_wrap;
    logic             r_dirUp;
    logic             r_bounced;
`ifdef LED_SEQ_GRAY_EN
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_binInc;
`endif

    mode_t            w_inMode;
    mode_t            w_stepMode;
    logic             w_runOk;
    logic             w_presClear;
    logic             w_terminal;
    logic             w_doLoad;
    logic             w_doStep;
    logic [WIDTH-1:0] w_bounceUp;
    logic [WIDTH-1:0] w_bounceDn;
    logic [WIDTH-1:0] w_nextLeds;
    logic             w_nextWrap;
    logic             w_nextDirUp;
    logic             w_nextBounced;

    assign w_inMode    = mode_t'(i_mode);
    assign w_stepMode  = (r_state == ST_IDLE) ? w_inMode : r_mode;
    assign w_runOk     = (r_state == ST_RUN) && i_enable && (w_inMode == r_mode);
    assign w_presClear = (r_state != ST_RUN);

    assign w_doLoad = ((r_state == ST_IDLE) && i_enable) ||
                      ((r_state == ST_RUN) && i_enable && (w_inMode != r_mode));
    assign w_doStep = ((r_state == ST_IDLE) && !i_enable && i_step) ||
                      (w_runOk && w_terminal);

    assign w_bounceUp = r_leds << 1;
    assign w_bounceDn = r_leds >> 1;
`ifdef LED_SEQ_GRAY_EN
    assign w_binInc = r_bin + LP_LSB;
`endif

    led_seq_prescaler #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_prescaler (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (w_presClear),
        .i_enable   (w_runOk),
        .i_rate     (i_rate),
        .o_terminal (w_terminal)
    );

    // Next pattern for one step; an empty one-hot pattern restarts from its initial LED.
    always_comb begin
        w_nextLeds    = r_leds;
        w_nextWrap    = 1'b0;
        w_nextDirUp   = r_dirUp;
        w_nextBounced = r_bounced;
        if (isOneHot(w_stepMode) && (r_leds == '0)) begin
            w_nextLeds    = initPattern(w_stepMode);
            w_nextDirUp   = 1'b1;
            w_nextBounced = 1'b0;
        end else begin
            case (w_stepMode)
                MODE_SHIFT_L: begin
                    w_nextLeds = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
                    w_nextWrap = r_leds[WIDTH-1];
                end
                MODE_SHIFT_R: begin
                    w_nextLeds = {r_leds[0], r_leds[WIDTH-1:1]};
                    w_nextWrap = r_leds[0];
                end
                MODE_BOUNCE: begin
                    // r_bounced marks that bit0 was reached by a downward sweep.
                    w_nextWrap = r_dirUp && r_leds[0] && r_bounced;
                    if (r_dirUp) begin
                        w_nextLeds = w_bounceUp;
                        if (w_bounceUp[WIDTH-1]) begin
                            w_nextDirUp = 1'b0;
                        end
                    end else begin
                        w_nextLeds = w_bounceDn;
                        if (w_bounceDn[0]) begin
                            w_nextDirUp   = 1'b1;
                            w_nextBounced = 1'b1;
                        end
                    end
                end
                MODE_COUNT: begin
`ifdef LED_SEQ_GRAY_EN
                    w_nextLeds = w_binInc ^ (w_binInc >> 1);
                    w_nextWrap = &r_bin;
`else
                    w_nextLeds = r_leds + LP_LSB;
                    w_nextWrap = &r_leds;
`endif
                end
            endcase
        end
    end

    // Control FSM; enable low wins over a mode change and suppresses any pending step.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_SHIFT_L;
            r_leds    <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            r_dirUp   <= 1'b1;
            r_bounced <= 1'b0;
`ifdef LED_SEQ_GRAY_EN
            r_bin     <= '0;
`endif
        end else begin
            r_tick <= w_doStep;
            r_wrap <= w_doStep & w_nextWrap;

            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= i_enable ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_inMode != r_mode) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_doLoad) begin
                r_mode    <= w_inMode;
                r_leds    <= initPattern(w_inMode);
                r_dirUp   <= 1'b1;
                r_bounced <= 1'b0;
`ifdef LED_SEQ_GRAY_EN
                r_bin     <= '0;
`endif
            end else if (w_doStep) begin
                r_leds    <= w_nextLeds;
                r_dirUp   <= w_nextDirUp;
                r_bounced <= w_nextBounced;
`ifdef LED_SEQ_GRAY_EN
                if (w_stepMode == MODE_COUNT) begin
                    r_bin <= w_binInc;
                end
`endif
            end
        end
    end

    assign o_leds = r_leds;
    assign o_tick = r_tick;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer: 8-LED and 4-LED instances share one stimulus stream.
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [24:0] rate;
    logic        step;

    logic [7:0]  leds8;
    logic        tick8;
    logic        wrap8;
    logic [3:0]  leds4;
    logic        tick4;
    logic        wrap4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_sequencer #(.WIDTH(8), .CNT_WIDTH(25)) dut8 (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_enable  (enable),
        .i_mode    (mode),
        .i_rate    (rate),
        .i_step    (step),
        .o_leds    (leds8),
        .o_tick    (tick8),
        .o_wrap    (wrap8)
    );

    led_sequencer #(.WIDTH(4), .CNT_WIDTH(25)) dut4 (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_enable  (enable),
        .i_mode    (mode),
        .i_rate    (rate),
        .i_step    (step),
        .o_leds    (leds4),
        .o_tick    (tick4),
        .o_wrap    (wrap4)
    );

    task automatic applyStimulus(input logic en, input logic [1:0] md,
                                 input logic [24:0] rt, input logic stp);
        enable = en;
        mode   = md;
        rate   = rt;
        step   = stp;
    endtask

    task automatic advance(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp8;
        logic       expWrap;
        logic [3:0] bin;
        logic [3:0] exp4;
        logic [3:0] bounceExp [13];

        bounceExp = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};

        reset_n = 1'b0;
        applyStimulus(1'b0, 2'b00, 25'd3, 1'b0);
        #12;
        checkOutput("reset_leds", leds8, 32'h0);
        checkOutput("reset_tick", tick8, 32'h0);
        checkOutput("reset_wrap", wrap8, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Three single steps while held, starting from all-zero LEDs.
        applyStimulus(1'b0, 2'b00, 25'd3, 1'b1);
        exp8 = 8'h01;
        for (int i = 0; i < 3; i++) begin
            advance(1);
            checkOutput("hold_step_leds", leds8, exp8);
            checkOutput("hold_step_tick", tick8, 32'h1);
            checkOutput("hold_step_wrap", wrap8, 32'h0);
            exp8 = exp8 << 1;
        end
        applyStimulus(1'b0, 2'b00, 25'd3, 1'b0);
        advance(1);
        checkOutput("hold_idle_leds", leds8, 32'h04);
        checkOutput("hold_idle_tick", tick8, 32'h0);
        checkOutput("hold_step_leds4", leds4, 32'h4);

        // SHIFT_L at rate 3.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b1, 2'b00, 25'd3, 1'b0);
        advance(1);
        checkOutput("load_leds", leds8, 32'h01);
        checkOutput("load_tick", tick8, 32'h0);
        advance(1);
        checkOutput("run_entry_tick", tick8, 32'h0);
        advance(2);
        checkOutput("first_wait_tick", tick8, 32'h0);
        checkOutput("first_wait_leds", leds8, 32'h01);
        advance(1);
        checkOutput("first_step_leds", leds8, 32'h02);
        checkOutput("first_step_tick", tick8, 32'h1);
        checkOutput("first_step_wrap", wrap8, 32'h0);
        exp8 = 8'h02;
        for (int i = 0; i < 8; i++) begin
            advance(2);
            checkOutput("shl_gap_tick", tick8, 32'h0);
            advance(1);
            expWrap = exp8[7];
            exp8 = {exp8[6:0], exp8[7]};
            checkOutput("shl_leds", leds8, exp8);
            checkOutput("shl_tick", tick8, 32'h1);
            checkOutput("shl_wrap", wrap8, expWrap);
        end

        // Mode change to SHIFT_R mid-run.
        applyStimulus(1'b1, 2'b01, 25'd3, 1'b0);
        advance(1);
        checkOutput("modechg_leds", leds8, 32'h80);
        checkOutput("modechg_tick", tick8, 32'h0);
        checkOutput("modechg_wrap", wrap8, 32'h0);
        advance(3);
        checkOutput("shr_gap_tick", tick8, 32'h0);
        advance(1);
        checkOutput("shr_leds", leds8, 32'h40);
        checkOutput("shr_tick", tick8, 32'h1);
        checkOutput("shr_wrap", wrap8, 32'h0);

        // Lower rate from 20 to 4 while the prescaler sits at 10.
        applyStimulus(1'b1, 2'b00, 25'd20, 1'b0);
        advance(1);
        checkOutput("rate_load_leds", leds8, 32'h01);
        advance(1);
        advance(10);
        checkOutput("rate20_tick", tick8, 32'h0);
        checkOutput("rate20_leds", leds8, 32'h01);
        applyStimulus(1'b1, 2'b00, 25'd4, 1'b0);
        advance(1);
        checkOutput("rate_drop_leds", leds8, 32'h02);
        checkOutput("rate_drop_tick", tick8, 32'h1);
        advance(3);
        checkOutput("rate4_gap_tick", tick8, 32'h0);
        advance(1);
        checkOutput("rate4_leds", leds8, 32'h04);
        checkOutput("rate4_tick", tick8, 32'h1);

        // Enable falling while the prescaler is at terminal (rate 1).
        applyStimulus(1'b1, 2'b00, 25'd1, 1'b0);
        advance(1);
        checkOutput("rate1_leds", leds8, 32'h08);
        checkOutput("rate1_tick", tick8, 32'h1);
        applyStimulus(1'b0, 2'b00, 25'd1, 1'b0);
        advance(1);
        checkOutput("en_fall_leds", leds8, 32'h08);
        checkOutput("en_fall_tick", tick8, 32'h0);
        advance(2);
        checkOutput("en_hold_leds", leds8, 32'h08);

        // BOUNCE on the 4-LED instance.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b1, 2'b10, 25'd1, 1'b0);
        advance(1);
        checkOutput("bounce_load_leds", leds4, 32'h1);
        advance(1);
        checkOutput("bounce_entry_tick", tick4, 32'h0);
        for (int i = 0; i < 13; i++) begin
            advance(1);
            expWrap = (i == 6) || (i == 12);
            checkOutput("bounce_leds", leds4, bounceExp[i]);
            checkOutput("bounce_tick", tick4, 32'h1);
            checkOutput("bounce_wrap", wrap4, expWrap);
        end

        // COUNT on the 4-LED instance.
        applyStimulus(1'b1, 2'b11, 25'd1, 1'b0);
        advance(1);
        checkOutput("count_load_leds", leds4, 32'h0);
        checkOutput("count_load_tick", tick4, 32'h0);
        advance(1);
        checkOutput("count_entry_tick", tick4, 32'h0);
        bin = 4'h0;
        for (int i = 0; i < 17; i++) begin
            advance(1);
            expWrap = (bin == 4'hF);
            bin = bin + 4'h1;
`ifdef LED_SEQ_GRAY_EN
            exp4 = bin ^ (bin >> 1);
`else
            exp4 = bin;
`endif
            checkOutput("count_leds", leds4, exp4);
            checkOutput("count_tick", tick4, 32'h1);
            checkOutput("count_wrap", wrap4, expWrap);
        end

        // Asynchronous reset mid-run, checked before the next clock edge.
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_leds4", leds4, 32'h0);
        checkOutput("async_rst_tick4", tick4, 32'h0);
        checkOutput("async_rst_wrap4", wrap4, 32'h0);
        checkOutput("async_rst_leds8", leds8, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
